// File: rtl/up_pix_pkg.sv
// Shared types and constants for the RGB888 pixel to 32-bit word packer.
// Four 24-bit pixels fill exactly three little-endian 32-bit words.
package up_pix_pkg;

  localparam int PIX_W  = 24;
  localparam int WORD_W = 32;

  typedef enum logic [1:0] {PH0, PH1, PH2, PH3} phase_t;

  // Number of residue bits that form the low part of each phase's word.
  localparam int RES_BITS_PH1 = 24;
  localparam int RES_BITS_PH2 = 16;
  localparam int RES_BITS_PH3 = 8;

  function automatic logic [WORD_W-1:0] pack_word(input phase_t ph,
                                                  input logic [PIX_W-1:0] residue,
                                                  input logic [PIX_W-1:0] pix);
    logic [WORD_W-1:0] w;
    w = '0;
    case (ph)
      PH1:     w = {pix[WORD_W-RES_BITS_PH1-1:0], residue[RES_BITS_PH1-1:0]};
      PH2:     w = {pix[WORD_W-RES_BITS_PH2-1:0], residue[RES_BITS_PH2-1:0]};
      PH3:     w = {pix[WORD_W-RES_BITS_PH3-1:0], residue[RES_BITS_PH3-1:0]};
      default: w = '0;
    endcase
    return w;
  endfunction

  // The part of the pixel not yet emitted, right-aligned for the next phase.
  function automatic logic [PIX_W-1:0] next_residue(input phase_t ph,
                                                    input logic [PIX_W-1:0] pix);
    logic [PIX_W-1:0] r;
    r = '0;
    case (ph)
      PH0:     r = pix;
      PH1:     r = PIX_W'(pix[PIX_W-1:WORD_W-RES_BITS_PH1]);
      PH2:     r = PIX_W'(pix[PIX_W-1:WORD_W-RES_BITS_PH2]);
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/up_pix_skid.sv
// Two-entry pixel buffer in front of the packer; issues FIFO reads so that
// in-flight data always has a free slot, sustaining one pixel per clock.
module up_pix_skid
  import up_pix_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_sync,
  input  logic             fifo_empty,
  input  logic [PIX_W-1:0] fifo_rd_data,
  input  logic             take,
  output logic             fifo_rd_en,
  output logic             head_valid,
  output logic [PIX_W-1:0] head_data
);

  logic [1:0]       buf_count;
  logic [1:0]       count_after_pop;
  logic             rd_pend;
  logic             armed;
  logic             pop;
  logic [PIX_W-1:0] slot0;
  logic [PIX_W-1:0] slot1;

  assign head_valid      = (buf_count != 2'd0);
  assign head_data       = slot0;
  assign pop             = take && head_valid;
  assign count_after_pop = buf_count - {1'b0, pop};

  // Occupancy is judged after this cycle's pop so a full-rate stream never stalls.
  assign fifo_rd_en = armed && !fifo_empty && !frame_sync &&
                      ((count_after_pop + {1'b0, rd_pend}) < 2'd2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_count <= 2'd0;
      rd_pend   <= 1'b0;
      armed     <= 1'b0;
      slot0     <= '0;
      slot1     <= '0;
    end else begin
      armed <= 1'b1;
      if (frame_sync) begin
        buf_count <= 2'd0;
        rd_pend   <= 1'b0;
      end else begin
        rd_pend   <= fifo_rd_en;
        buf_count <= count_after_pop + {1'b0, rd_pend};
        if (pop) slot0 <= slot1;
        if (rd_pend) begin
          if (count_after_pop == 2'd0) slot0 <= fifo_rd_data;
          else                         slot1 <= fifo_rd_data;
        end
      end
    end
  end

endmodule

// File: rtl/up_fifo_pix_packer.sv
// Drains the RGB888 pixel FIFO, packs 4 pixels into 3 words and streams them
// to the DDR writer with line-end (m_last) and frame-start (m_user) tags.
module up_fifo_pix_packer
  import up_pix_pkg::*;
#(
  parameter int H_ACTIVE = 1280,
  parameter int V_ACTIVE = 720
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_sync,
  output logic              fifo_rd_en,
  input  logic [PIX_W-1:0]  fifo_rd_data,
  input  logic              fifo_empty,
  output logic [WORD_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic              m_user
);

  localparam int PIX_CNT_W  = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int LINE_CNT_W = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam logic [PIX_CNT_W-1:0]  PIX_LAST  = PIX_CNT_W'(H_ACTIVE - 1);
  localparam logic [LINE_CNT_W-1:0] LINE_LAST = LINE_CNT_W'(V_ACTIVE - 1);

  generate
    if ((H_ACTIVE % 4) != 0 || H_ACTIVE < 4) begin : g_bad_h_active
      $error("H_ACTIVE must be a positive multiple of 4");
    end
  endgenerate

  phase_t                 ph;
  logic [PIX_W-1:0]       residue;
  logic [PIX_CNT_W-1:0]   pix_cnt;
  logic [LINE_CNT_W-1:0]  line_cnt;
  logic                   head_valid;
  logic [PIX_W-1:0]       head_data;
  logic                   out_free;
  logic                   take;

  // A ph0 pixel only fills the residue, so it may be absorbed during a stall.
  assign out_free = !m_valid || m_ready;
  assign take     = head_valid && ((ph == PH0) || out_free);

  up_pix_skid u_skid (
    .clk          (clk),
    .rst_n        (rst_n),
    .frame_sync   (frame_sync),
    .fifo_empty   (fifo_empty),
    .fifo_rd_data (fifo_rd_data),
    .take         (take),
    .fifo_rd_en   (fifo_rd_en),
    .head_valid   (head_valid),
    .head_data    (head_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph       <= PH0;
      residue  <= '0;
      pix_cnt  <= '0;
      line_cnt <= '0;
      m_valid  <= 1'b0;
      m_data   <= '0;
      m_last   <= 1'b0;
      m_user   <= 1'b0;
    end else if (frame_sync) begin
      ph       <= PH0;
      residue  <= '0;
      pix_cnt  <= '0;
      line_cnt <= '0;
      m_valid  <= 1'b0;
      m_data   <= '0;
      m_last   <= 1'b0;
      m_user   <= 1'b0;
    end else begin
      if (m_valid && m_ready) m_valid <= 1'b0;
      if (take) begin
        ph      <= phase_t'(ph + 2'd1);
        residue <= next_residue(ph, head_data);
        if (pix_cnt == PIX_LAST) begin
          pix_cnt  <= '0;
          line_cnt <= (line_cnt == LINE_LAST) ? '0 : line_cnt + LINE_CNT_W'(1);
        end else begin
          pix_cnt <= pix_cnt + PIX_CNT_W'(1);
        end
        if (ph != PH0) begin
          m_valid <= 1'b1;
          m_data  <= pack_word(ph, residue, head_data);
          m_last  <= (ph == PH3) && (pix_cnt == PIX_LAST);
          m_user  <= (ph == PH1) && (pix_cnt == PIX_CNT_W'(1)) && (line_cnt == '0);
        end
      end
    end
  end

endmodule

// File: tb/tb_up_fifo_pix_packer.sv
// Directed bench for up_fifo_pix_packer: a queue-based FIFO, a 96-bit block
// model of the packing and a per-cycle compare process on the output stream.
module tb_up_fifo_pix_packer;

  localparam int H     = 8;
  localparam int V     = 4;
  localparam int FRAME = H * V;

  typedef struct packed {
    logic        user;
    logic        last;
    logic [31:0] data;
  } word_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        frame_sync;
  logic        fifo_rd_en;
  logic [23:0] fifo_rd_data;
  logic        fifo_empty;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic        m_last;
  logic        m_user;

  up_fifo_pix_packer #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .frame_sync   (frame_sync),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rd_data (fifo_rd_data),
    .fifo_empty   (fifo_empty),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_last       (m_last),
    .m_user       (m_user)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          frame_pos = 0;
  int          reads_n = 0;
  int          base;
  logic        gap_mode = 1'b0;
  logic        rd_seen = 1'b0;
  logic        watch_reads = 1'b0;
  logic        hold_v = 1'b0;
  word_t       hold_w;
  word_t       mon_e;
  logic [23:0] fifo_q[$];
  logic [23:0] part_q[$];
  word_t       exp_q[$];
  logic [31:0] got_data[$];
  logic        got_last[$];
  logic        got_user[$];
  int          got_cyc[$];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Model: four pixels form a 96-bit little-endian block cut into three words.
  task automatic modelPush(input logic [23:0] p);
    logic [95:0] blk;
    int          start;
    word_t       w;
    part_q.push_back(p);
    if (part_q.size() == 4) begin
      blk   = {part_q[3], part_q[2], part_q[1], part_q[0]};
      start = frame_pos - 3;
      for (int k = 0; k < 3; k++) begin
        w.data = blk[32*k +: 32];
        w.user = (start == 0) && (k == 0);
        w.last = ((start % H) == H - 4) && (k == 2);
        exp_q.push_back(w);
      end
      part_q.delete();
    end
    frame_pos = (frame_pos + 1) % FRAME;
  endtask

  task automatic modelReset();
    part_q.delete();
    exp_q.delete();
    fifo_q.delete();
    frame_pos = 0;
  endtask

  task automatic applyStimulus(input logic [23:0] p);
    fifo_q.push_back(p);
    modelPush(p);
  endtask

  function automatic logic [23:0] pixOf(input int i);
    return 24'((i * 32'h0013_1517) ^ 32'h00A5_C3E1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    fifo_empty = (fifo_q.size() == 0) || (gap_mode && cyc[0]);
  endtask

  task automatic waitIdle(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || fifo_q.size() != 0 || m_valid) && n < budget) begin
      tick();
      n++;
    end
    checkOutput("drain_pending_words", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic waitValid(input int budget);
    int n = 0;
    while (!m_valid && n < budget) begin
      tick();
      n++;
    end
    checkOutput("valid_seen", 32'(m_valid), 32'd1);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // FIFO with one-cycle read latency.
  always @(negedge clk) rd_seen = fifo_rd_en;
  always @(posedge clk)
    if (rd_seen && fifo_q.size() > 0) fifo_rd_data <= fifo_q.pop_front();

  // Compare process: handshake scoreboard plus hold-stability while stalled.
  always @(negedge clk) begin
    if (watch_reads && fifo_rd_en) reads_n++;
    if (!rst_n) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        checkOutput("stall_valid_held", 32'(m_valid), 32'd1);
        checkOutput("stall_data_held", m_data, hold_w.data);
        checkOutput("stall_flags_held", 32'({m_user, m_last}), 32'({hold_w.user, hold_w.last}));
      end
      hold_v = m_valid && !m_ready && !frame_sync;
      hold_w = {m_user, m_last, m_data};
      if (m_valid && m_ready && !frame_sync) begin
        got_data.push_back(m_data);
        got_last.push_back(m_last);
        got_user.push_back(m_user);
        got_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_word: got 0x%0h expected none", m_data);
        end else begin
          mon_e = exp_q.pop_front();
          checkOutput("word_data", m_data, mon_e.data);
          checkOutput("word_last", 32'(m_last), 32'(mon_e.last));
          checkOutput("word_user", 32'(m_user), 32'(mon_e.user));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n        = 1'b0;
    frame_sync   = 1'b0;
    fifo_empty   = 1'b0;
    m_ready      = 1'b0;
    fifo_rd_data = '0;
    #12;
    checkOutput("reset_rd_en", 32'(fifo_rd_en), 32'd0);
    checkOutput("reset_valid", 32'(m_valid), 32'd0);
    checkOutput("reset_data", m_data, 32'd0);
    checkOutput("reset_last", 32'(m_last), 32'd0);
    checkOutput("reset_user", 32'(m_user), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    m_ready = 1'b1;
    tick();

    // First half of line 0: literal words.
    applyStimulus(24'hAABBCC);
    applyStimulus(24'h112233);
    applyStimulus(24'h445566);
    applyStimulus(24'h778899);
    waitIdle(60);
    checkOutput("s1_count", 32'(got_data.size()), 32'd3);
    checkOutput("s1_word0", got_data[0], 32'h33AABBCC);
    checkOutput("s1_word1", got_data[1], 32'h55661122);
    checkOutput("s1_word2", got_data[2], 32'h77889944);
    checkOutput("s1_user0", 32'(got_user[0]), 32'd1);
    checkOutput("s1_user1", 32'(got_user[1]), 32'd0);

    // Rest of line 0: six words, m_last only on the sixth.
    for (int i = 0; i < 4; i++) applyStimulus(pixOf(i));
    waitIdle(60);
    checkOutput("line0_count", 32'(got_data.size()), 32'd6);
    for (int i = 0; i < 5; i++) checkOutput("line0_last_low", 32'(got_last[i]), 32'd0);
    checkOutput("line0_last_word6", 32'(got_last[5]), 32'd1);

    // Line 1, continuous FIFO: 3 words every 4 clocks.
    base = got_data.size();
    for (int i = 0; i < H; i++) applyStimulus(pixOf(10 + i));
    waitIdle(60);
    checkOutput("line1_count", 32'(got_data.size() - base), 32'd6);
    checkOutput("line1_rate_a", 32'(got_cyc[base+3] - got_cyc[base]), 32'd4);
    checkOutput("line1_rate_b", 32'(got_cyc[base+5] - got_cyc[base+2]), 32'd4);

    // Line 2, FIFO empty every other cycle.
    gap_mode = 1'b1;
    base = got_data.size();
    for (int i = 0; i < H; i++) applyStimulus(pixOf(10 + i));
    waitIdle(100);
    gap_mode = 1'b0;
    checkOutput("line2_gap_count", 32'(got_data.size() - base), 32'd6);

    // Line 3 with a 10-cycle downstream stall after the first word.
    m_ready = 1'b0;
    for (int i = 0; i < H; i++) applyStimulus(pixOf(30 + i));
    waitValid(30);
    reads_n = 0;
    watch_reads = 1'b1;
    repeat (10) tick();
    watch_reads = 1'b0;
    #1;
    checkOutput("stall_reads_at_most_3", 32'(reads_n <= 3), 32'd1);
    checkOutput("stall_rd_en_low", 32'(fifo_rd_en), 32'd0);
    m_ready = 1'b1;
    waitIdle(100);

    // New frame: three lines, then frame_sync after 2 pixels of line 3.
    for (int i = 0; i < 3 * H; i++) applyStimulus(pixOf(50 + i));
    waitIdle(200);
    m_ready = 1'b0;
    applyStimulus(pixOf(90));
    applyStimulus(pixOf(91));
    waitValid(30);
    frame_sync = 1'b1;
    modelReset();
    tick();
    frame_sync = 1'b0;
    @(negedge clk);
    checkOutput("sync_valid_drop", 32'(m_valid), 32'd0);
    tick();
    m_ready = 1'b1;
    base = got_data.size();
    applyStimulus(24'hAABBCC);
    applyStimulus(24'h112233);
    applyStimulus(24'h445566);
    applyStimulus(24'h778899);
    waitIdle(60);
    checkOutput("sync_word0", got_data[base], 32'h33AABBCC);
    checkOutput("sync_user0", 32'(got_user[base]), 32'd1);

    // Asynchronous reset while stalled with a word pending.
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) applyStimulus(pixOf(100 + i));
    waitValid(30);
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1;
    checkOutput("areset_valid", 32'(m_valid), 32'd0);
    checkOutput("areset_data", m_data, 32'd0);
    checkOutput("areset_last", 32'(m_last), 32'd0);
    checkOutput("areset_user", 32'(m_user), 32'd0);
    checkOutput("areset_rd_en", 32'(fifo_rd_en), 32'd0);
    modelReset();
    tick();
    tick();
    rst_n = 1'b1;
    m_ready = 1'b1;
    base = got_data.size();
    applyStimulus(24'hAABBCC);
    applyStimulus(24'h112233);
    applyStimulus(24'h445566);
    applyStimulus(24'h778899);
    waitIdle(60);
    checkOutput("post_reset_count", 32'(got_data.size() - base), 32'd3);
    checkOutput("post_reset_word0", got_data[base], 32'h33AABBCC);
    checkOutput("post_reset_word1", got_data[base+1], 32'h55661122);
    checkOutput("post_reset_word2", got_data[base+2], 32'h77889944);
    checkOutput("post_reset_user0", 32'(got_user[base]), 32'd1);

    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
